bus_arbiter_rr: RTL and testbench

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

---
 rtl/bus_arbiter_rr.sv | 150 +++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with quantum-based preemption, per-core lock and a
// post-switch settle window during which the new owner still sees busy.
module bus_arbiter_rr #(
    parameter int NCORES  = 4,
    parameter int QUANTUM = 16,
    parameter int HOLD    = 2,
    localparam int IDW    = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_init_done,
    input  logic                   i_tx_ready,
    input  logic                   i_dram_busy,
    input  logic [NCORES-1:0]      i_req,
    input  logic [NCORES-1:0]      i_lock,
    input  logic [NCORES*32-1:0]   i_core_addr,
    input  logic [NCORES*32-1:0]   i_core_wdata,
    input  logic [NCORES-1:0]      i_core_we,
    output logic [31:0]            o_mem_addr,
    output logic [31:0]            o_mem_wdata,
    output logic                   o_mem_we,
    output logic [IDW-1:0]         o_grant_id,
    output logic [NCORES-1:0]      o_grant_oh,
    output logic [NCORES-1:0]      o_core_busy,
    output logic                   o_switch_pulse
);

    typedef enum logic {
        ST_OWN    = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [IDW-1:0]      r_grant_id;
    logic [IDW-1:0]      w_grant_next;
    logic [7:0]          r_qcnt;
    logic [7:0]          w_qcnt_next;
    logic [3:0]          r_scnt;
    logic [3:0]          w_scnt_next;
    logic                r_switch_pulse;
    logic                w_pulse_next;

    logic [NCORES-1:0]   w_owner_oh;
    logic                w_others;
    logic                w_owner_req;
    logic                w_owner_lock;
    logic                w_owner_we;
    logic                w_quantum_up;
    logic                w_switch;
    logic [2*NCORES-1:0] w_req_rot;
    logic [IDW-1:0]      w_next_owner;

    generate
        for (genvar gi = 0; gi < NCORES; gi++) begin : g_owner_dec
            assign w_owner_oh[gi] = (r_grant_id == IDW'(gi));
        end
    endgenerate

    assign w_others     = |(i_req & ~w_owner_oh);
    assign w_owner_req  = |(i_req & w_owner_oh);
    assign w_owner_lock = |(i_lock & w_owner_oh);
    assign w_owner_we   = |(i_core_we & w_owner_oh);
    assign w_quantum_up = (r_qcnt == 8'(QUANTUM));

    assign w_switch = i_init_done & ~i_dram_busy & i_tx_ready & ~w_owner_lock
                    & w_others & (w_quantum_up | ~w_owner_req);

    // Bit k of the rotated vector is the request of core (grant_id + k) mod NCORES.
    assign w_req_rot = {i_req, i_req} >> r_grant_id;

    always_comb begin
        w_next_owner = r_grant_id;
        for (int k = NCORES - 1; k >= 1; k--) begin
            if (w_req_rot[k]) begin
                w_next_owner = IDW'((int'(r_grant_id) + k) % NCORES);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant_id;
        w_qcnt_next  = r_qcnt;
        w_scnt_next  = r_scnt;
        w_pulse_next = 1'b0;
        if (i_init_done) begin
            case (r_state)
                ST_OWN: begin
                    if (w_switch) begin
                        w_grant_next = w_next_owner;
                        w_state_next = ST_SETTLE;
                        w_scnt_next  = 4'd0;
                        w_qcnt_next  = 8'd0;
                        w_pulse_next = 1'b1;
                    end else if (w_others) begin
                        if (r_qcnt < 8'(QUANTUM)) begin
                            w_qcnt_next = r_qcnt + 8'd1;
                        end
                    end else begin
                        w_qcnt_next = 8'd0;
                    end
                end
                ST_SETTLE: begin
                    w_scnt_next = r_scnt + 4'd1;
                    if (r_scnt == 4'(HOLD - 1)) begin
                        w_state_next = ST_OWN;
                    end
                end
                default: w_state_next = ST_OWN;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_OWN;
            r_grant_id     <= '0;
            r_qcnt         <= 8'd0;
            r_scnt         <= 4'd0;
            r_switch_pulse <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_grant_id     <= w_grant_next;
            r_qcnt         <= w_qcnt_next;
            r_scnt         <= w_scnt_next;
            r_switch_pulse <= w_pulse_next;
        end
    end

    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (w_owner_oh[k]) begin
                o_mem_addr  = i_core_addr[32*k +: 32];
                o_mem_wdata = i_core_wdata[32*k +: 32];
            end
        end
    end

    // Writes are held off while the new owner is still settling.
    assign o_mem_we       = w_owner_we & (r_state == ST_OWN);
    assign o_grant_id     = r_grant_id;
    assign o_grant_oh     = w_owner_oh;
    assign o_core_busy    = ~w_owner_oh
                          | ({NCORES{i_dram_busy | (r_state == ST_SETTLE)}} & w_owner_oh);
    assign o_switch_pulse = r_switch_pulse;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: a vector table for single-step behaviour
// plus hand-written sequences for rotation, lock, wrap and reset-in-settle.
module tb_bus_arbiter_rr;

    localparam int NC  = 4;
    localparam int QT  = 4;
    localparam int HD  = 2;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              init_done;
    logic              tx_ready;
    logic              dram_busy;
    logic [NC-1:0]     req;
    logic [NC-1:0]     lock;
    logic [NC*32-1:0]  core_addr;
    logic [NC*32-1:0]  core_wdata;
    logic [NC-1:0]     core_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [IDW-1:0]    grant_id;
    logic [NC-1:0]     grant_oh;
    logic [NC-1:0]     core_busy;
    logic              switch_pulse;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(.NCORES(NC), .QUANTUM(QT), .HOLD(HD)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_init_done    (init_done),
        .i_tx_ready     (tx_ready),
        .i_dram_busy    (dram_busy),
        .i_req          (req),
        .i_lock         (lock),
        .i_core_addr    (core_addr),
        .i_core_wdata   (core_wdata),
        .i_core_we      (core_we),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_we       (mem_we),
        .o_grant_id     (grant_id),
        .o_grant_oh     (grant_oh),
        .o_core_busy    (core_busy),
        .o_switch_pulse (switch_pulse)
    );

    typedef struct {
        logic [NC-1:0]  req;
        logic           dram;
        logic           txr;
        logic           init;
        logic [IDW-1:0] grant;
        logic           pulse;
        logic [NC-1:0]  busy;
        logic           we;
    } vec_t;

    vec_t vt[16];

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000_0000 + 32'(i * 256);
    endfunction

    function automatic logic [31:0] wdata_of(input int i);
        return 32'hD0D0_0000 + 32'(i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Returns the number of edges until switch_pulse is seen (budget on timeout).
    task automatic wait_pulse(input int budget, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!switch_pulse && cyc < budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int moved;
        logic [IDW-1:0] exp_rot[3];

        init_done = 1'b1;
        tx_ready  = 1'b1;
        dram_busy = 1'b1;
        req       = '0;
        lock      = '0;
        core_we   = 4'b0101;
        for (int i = 0; i < NC; i++) begin
            core_addr[32*i +: 32]  = addr_of(i);
            core_wdata[32*i +: 32] = wdata_of(i);
        end

        // ---- asynchronous reset, before any clock edge ----
        #1 rst = 1'b1;
        #1;
        check("rst_grant", 32'(grant_id), 0);
        check("rst_oh", 32'(grant_oh), 32'b0001);
        check("rst_pulse", 32'(switch_pulse), 0);
        check("rst_busy_dram", 32'(core_busy), 32'b1111);
        dram_busy = 1'b0;
        #1;
        check("rst_busy_idle", 32'(core_busy), 32'b1110);
        @(posedge clk);
        #1 rst = 1'b0;

        // ---- vector table: one edge per row, core_we = 0101 ----
        vt[0]  = '{4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 4'b1110, 1'b1};
        vt[1]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 4'b1110, 1'b1};
        vt[2]  = '{4'b0100, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 4'b1111, 1'b0};
        vt[3]  = '{4'b0100, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 4'b1111, 1'b0};
        vt[4]  = '{4'b0100, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 4'b1011, 1'b1};
        vt[5]  = '{4'b0101, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 4'b1011, 1'b1};
        vt[6]  = '{4'b0101, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'b1111, 1'b1};
        vt[7]  = '{4'b0101, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'b1111, 1'b1};
        vt[8]  = '{4'b0101, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'b1111, 1'b1};
        vt[9]  = '{4'b0101, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'b1111, 1'b1};
        vt[10] = '{4'b0101, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 4'b1011, 1'b1};
        vt[11] = '{4'b0101, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 4'b1011, 1'b1};
        vt[12] = '{4'b0101, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 4'b1111, 1'b0};
        vt[13] = '{4'b0101, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 1'b0};
        vt[14] = '{4'b0101, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 4'b1111, 1'b0};
        vt[15] = '{4'b0101, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 4'b1110, 1'b1};

        for (int v = 0; v < 16; v++) begin
            req       = vt[v].req;
            dram_busy = vt[v].dram;
            tx_ready  = vt[v].txr;
            init_done = vt[v].init;
            step();
            $display("vec %0d: req=%b grant=%0d pulse=%b busy=%b we=%b",
                     v, req, grant_id, switch_pulse, core_busy, mem_we);
            check($sformatf("vec%0d_grant", v), 32'(grant_id), 32'(vt[v].grant));
            check($sformatf("vec%0d_pulse", v), 32'(switch_pulse), 32'(vt[v].pulse));
            check($sformatf("vec%0d_busy", v), 32'(core_busy), 32'(vt[v].busy));
            check($sformatf("vec%0d_we", v), 32'(mem_we), 32'(vt[v].we));
            check($sformatf("vec%0d_oh", v), 32'(grant_oh), 32'(1) << vt[v].grant);
            check($sformatf("vec%0d_addr", v), mem_addr, addr_of(int'(vt[v].grant)));
            check($sformatf("vec%0d_wdata", v), mem_wdata, wdata_of(int'(vt[v].grant)));
        end
        init_done = 1'b1;
        tx_ready  = 1'b1;
        dram_busy = 1'b0;

        // ---- full rotation 0 -> 1 -> 2 -> 3 -> 0 with all cores requesting ----
        do_reset();
        req = 4'b1111;
        wait_pulse(40, c);
        $display("rot: switch to %0d after %0d edges", grant_id, c);
        check("rot_first_latency", 32'(c), 32'(QT + 1));
        check("rot_grant_1", 32'(grant_id), 1);
        exp_rot[0] = 2'd2;
        exp_rot[1] = 2'd3;
        exp_rot[2] = 2'd0;
        for (int r = 0; r < 3; r++) begin
            step();
            check($sformatf("rot_pulse_width_%0d", r), 32'(switch_pulse), 0);
            wait_pulse(40, c);
            c = c + 1;
            $display("rot: switch to %0d after %0d edges", grant_id, c);
            // QUANTUM+HOLD idle cycles between consecutive pulses
            check($sformatf("rot_spacing_%0d", r), 32'(c), 32'(QT + HD + 1));
            check($sformatf("rot_grant_%0d", r), 32'(grant_id), 32'(exp_rot[r]));
        end

        // ---- lock on owner 1 blocks preemption ----
        do_reset();
        req = 4'b1111;
        wait_pulse(40, c);
        check("lock_reach_1", 32'(grant_id), 1);
        lock  = 4'b0010;
        moved = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (grant_id !== 2'd1 || switch_pulse !== 1'b0) moved++;
        end
        $display("lock: 50 cycles held, grant=%0d moves=%0d", grant_id, moved);
        check("lock_hold_moves", 32'(moved), 0);
        lock = 4'b0000;
        step();
        $display("lock: released, grant=%0d pulse=%b", grant_id, switch_pulse);
        check("lock_release_grant", 32'(grant_id), 2);
        check("lock_release_pulse", 32'(switch_pulse), 1);

        // ---- wrap from core 3 to core 0, then reset during settle ----
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 3; i++) wait_pulse(40, c);
        check("wrap_reach_3", 32'(grant_id), 3);
        req = 4'b1011;
        wait_pulse(40, c);
        $display("wrap: switch to %0d after %0d edges", grant_id, c);
        check("wrap_spacing", 32'(c), 32'(QT + HD + 1));
        check("wrap_grant", 32'(grant_id), 0);
        check("wrap_settle_busy", 32'(core_busy), 32'b1111);
        check("wrap_settle_we", 32'(mem_we), 0);
        #2 rst = 1'b1;
        #1;
        $display("rst-in-settle: grant=%0d pulse=%b busy=%b we=%b",
                 grant_id, switch_pulse, core_busy, mem_we);
        check("rstsettle_pulse", 32'(switch_pulse), 0);
        check("rstsettle_grant", 32'(grant_id), 0);
        check("rstsettle_busy", 32'(core_busy), 32'b1110);
        check("rstsettle_we", 32'(mem_we), 1);
        step();
        rst = 1'b0;
        step();
        check("post_rst_grant", 32'(grant_id), 0);
        check("post_rst_busy", 32'(core_busy), 32'b1110);
        check("post_rst_pulse", 32'(switch_pulse), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
